dpo_mux_fsm: RTL

Multi-channel output data-port controller for the FX3 GPIF II slave FIFO write path. It arbitrates N_CH first-word-fall-through data-port FIFOs round-robin and drives the selected FX3 socket address. Each grant streams at most one packet at one word per clock. A packet is closed as full at MAX_PKT words, or committed short by a PKTEND-only strobe after an idle timeout. It sits between the data-port FIFOs and the FX3 pins, and is started and acknowledged by the fx3 controller through strt_i/done_o.

---
 rtl/dpo_mux_fsm.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dpo_mux_fsm.sv
// FX3 GPIF II slave-FIFO write-path arbiter: round-robin over N_CH FWFT data-port FIFOs,
// one packet per grant. Define DPO_PKT_CNT_EN to build the committed-packet counter.
module dpo_mux_fsm #(
  parameter int unsigned DW          = 32,
  parameter int unsigned N_CH        = 3,
  parameter int unsigned MAX_PKT     = 256,
  parameter int unsigned MAX_TIMEOUT = 16,
  parameter int unsigned ADDR_SETTLE = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 strt_i,
  output logic                 done_o,
  input  logic                 FLAG_i,
  output logic [1:0]           ADDR_o,
  output logic                 SLWRn_o,
  output logic                 PKTENDn_o,
  output logic [DW-1:0]        DQ_o,
  input  logic [N_CH*DW-1:0]   dpo_dt_i,
  input  logic [N_CH-1:0]      dpo_epty_i,
  output logic [N_CH-1:0]      dpo_rd_o,
  output logic [15:0]          pkt_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SETTLE,
    S_WRITE,
    S_WAIT,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [1:0]  ch, ptr, found_ch;
  logic        found;
  logic [2:0]  settle_cnt;
  logic [15:0] word_cnt;
  logic [7:0]  tmo_cnt;
  logic        epty_sel, pop, last;
  logic [DW-1:0] dt_arr [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign dt_arr[k] = dpo_dt_i[k*DW +: DW];
  end

  assign epty_sel = dpo_epty_i[ch];

  // Round-robin search starting one past the last served channel.
  always_comb begin
    logic [1:0] cidx;
    found    = 1'b0;
    found_ch = '0;
    cidx     = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cidx = 2'((int'(ptr) + i) % N_CH);
      if (!found && !dpo_epty_i[cidx]) begin
        found    = 1'b1;
        found_ch = cidx;
      end
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    last       = 1'b0;
    case (state)
      S_IDLE:   if (strt_i) state_next = S_SCAN;
      S_SCAN:   state_next = found ? S_SETTLE : S_DONE;
      S_SETTLE: if (settle_cnt == 3'(ADDR_SETTLE - 1))
                  state_next = FLAG_i ? S_WRITE : S_DONE;
      S_WRITE: begin
        if (FLAG_i) begin
          if (!epty_sel) begin
            pop = 1'b1;
            if (word_cnt == 16'(MAX_PKT - 1)) begin
              last       = 1'b1;
              state_next = S_DONE;
            end
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!epty_sel)
          state_next = S_WRITE;
        else if (FLAG_i && tmo_cnt == 8'(MAX_TIMEOUT - 1))
          state_next = S_COMMIT;
      end
      S_COMMIT: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dpo_rd_o = '0;
    if (pop) dpo_rd_o[ch] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      ch         <= '0;
      ptr        <= 2'(N_CH - 1);
      settle_cnt <= '0;
      word_cnt   <= '0;
      tmo_cnt    <= '0;
      ADDR_o     <= '0;
      DQ_o       <= '0;
      SLWRn_o    <= 1'b1;
      PKTENDn_o  <= 1'b1;
      done_o     <= 1'b0;
    end else begin
      state     <= state_next;
      SLWRn_o   <= !pop;
      PKTENDn_o <= !(state_next == S_COMMIT);
      done_o    <= (state_next == S_DONE);
      if (state == S_SCAN) begin
        settle_cnt <= '0;
        word_cnt   <= '0;
        if (found) begin
          ch     <= found_ch;
          ptr    <= found_ch;
          ADDR_o <= found_ch;
        end
      end
      if (state == S_SETTLE) settle_cnt <= settle_cnt + 3'd1;
      if (pop) begin
        DQ_o     <= dt_arr[ch];
        word_cnt <= word_cnt + 16'd1;
      end
      // Timeout only accrues while the FX3 has space; any returning data restarts it.
      if (state == S_WRITE)
        tmo_cnt <= '0;
      else if (state == S_WAIT) begin
        if (!epty_sel)   tmo_cnt <= '0;
        else if (FLAG_i) tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

`ifdef DPO_PKT_CNT_EN
  logic [15:0] pkt_cnt;
  always_ff @(posedge clk_i) begin
    if (!rstn_i)
      pkt_cnt <= '0;
    else if ((pop && last) || state == S_COMMIT)
      pkt_cnt <= pkt_cnt + 16'd1;
  end
  assign pkt_cnt_o = pkt_cnt;
`else
  assign pkt_cnt_o = '0;
`endif

endmodule
